inst_mem_loader: RTL and testbench
==================================

Name: inst_mem_loader

Overview:
- Writer side of the program ROM that the fetch unit reads: takes a byte stream from a byte-level receiver (e.g. UART RX), packs bytes into 32-bit words and writes them sequentially into the instruction memory write port, starting at word address 0.
- Holds the CPU (`cpu_hold`) for the whole load, so fetch restarts from PC 0 with the new image.
- Image framing: 2-byte little-endian word count, then count×4 data bytes. Each word is little-endian.

Parameters:
- ADDR_W, 14, word-address width of instruction memory. The fetch side indexes with PC[15:2].
- DEPTH, 16384, maximum number of words accepted. Must be ≤ 2^ADDR_W.
- TIMEOUT_CYC, 1000000, idle cycles between bytes before the load is aborted.

Ports:
- clk  in  1  system clock. All state updates on rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load when in IDLE.
- byte_valid  in  1  one-cycle pulse; byte_data is valid this cycle.
- byte_data  in  8  received byte.
- mem_we  out  1  instruction memory write enable, one-cycle pulse per word.
- mem_addr  out  ADDR_W  word address for the write.
- mem_wdata  out  32  word to write.
- cpu_hold  out  1  high while a load is in progress (states LEN_LO, LEN_HI, DATA).
- done  out  1  sticky; image loaded completely.
- err  out  1  sticky; load aborted.
- words_loaded  out  16  words written so far in the current or last load.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, done=0, err=0, words_loaded=0. Byte index, length and timeout counter are cleared. Reset mid-load abandons the load immediately; memory keeps whatever was already written.
- States: IDLE, LEN_LO, LEN_HI, DATA.
- IDLE:
  - start=1 → LEN_LO.
  - On the same edge, clear done, err, words_loaded and byte index; timeout counter=0.
  - byte_valid in IDLE is ignored.
- LEN_LO: on byte_valid, len[7:0]=byte_data → LEN_HI.
- LEN_HI: on byte_valid, len[15:8]=byte_data.
  - If {byte_data,len[7:0]}==0 or >DEPTH → err=1, go to IDLE.
  - Otherwise → DATA.
- DATA, byte packing:
  - Each byte_valid stores byte_data into word[8*idx+7:8*idx]; idx increments 0..3 and wraps to 0.
  - On the byte with idx=3, next cycle: mem_we=1 for exactly one cycle, mem_addr=words_loaded[ADDR_W-1:0] (pre-increment value), mem_wdata=the assembled word.
  - On that same next edge, words_loaded increments.
- DATA, completion: when the incremented words_loaded == len, state → IDLE and done=1 in the same cycle mem_we is high. cpu_hold drops with that transition.
- DATA, back-to-back bytes: a byte_valid arriving in the mem_we cycle is accepted as byte 0 of the next word. Write data is registered, so there is no loss, and byte_valid on consecutive cycles is supported.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- start while not in IDLE is ignored.
- Timeout:
  - The counter runs in LEN_LO, LEN_HI and DATA. It clears on every byte_valid.
  - When it reaches TIMEOUT_CYC-1 with no byte: err=1, state → IDLE. Any partial word is discarded and no write is issued.
  - If byte_valid occurs on the expiry cycle, the byte wins and the counter clears.
- Completion takes precedence over timeout in the same cycle.
- done and err are never both 1. Both hold until the next accepted start or reset.
- cpu_hold is combinational from state and has no reset glitch; it is 0 in IDLE.

Test Plan:
- Basic load (bench TIMEOUT_CYC=100):
  - Stimulus: start; bytes 02 00, then 13 05 10 00, then 93 05 20 00.
  - Required: exactly two mem_we pulses: (addr 0, 0x00100513), then (addr 1, 0x00200593).
  - Then done=1, words_loaded=2, cpu_hold 1→0 on the second write.
- Back-to-back bytes: stimulus is length 3 with all 14 bytes on consecutive cycles. Required: 3 writes at addr 0,1,2 with correct data; no dropped byte.
- Bad length: length 00 00 → err=1, state IDLE, no mem_we. Length 01 40 (16385 > DEPTH) → err=1.
- Timeout: length 01 00, then 2 data bytes, then 100 idle cycles. Required: err=1, no mem_we, cpu_hold=0. A new start clears err and a full load then succeeds at addr 0.
- Reset mid-load: rst=0 after 6 of 8 data bytes. Required: all outputs at reset values immediately (asynchronous). Bytes after release are ignored until start.
- Ignored events: byte_valid in IDLE and start during DATA. Required: no state change, no write, words_loaded unchanged.

Source files
------------

// File: rtl/inst_mem_loader.sv
// Instruction memory loader: receives a length-prefixed byte image, packs little-endian
// 32-bit words and writes them from word address 0 while holding the CPU.
module inst_mem_loader #(
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned DEPTH       = 16384,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [15:0]       words_loaded
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StLenLo = 2'd1;
    localparam logic [1:0] StLenHi = 2'd2;
    localparam logic [1:0] StData  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [1:0]        idx_q, idx_d;
    logic [23:0]       word_q, word_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [15:0]       count_q, count_d;

    logic [15:0] len_full;
    logic [15:0] count_inc;
    logic        timer_exp;

    assign len_full  = {byte_data, len_q[7:0]};
    assign count_inc = count_q + 16'd1;
    assign timer_exp = (timer_q == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        word_d  = word_q;
        timer_d = timer_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        err_d   = err_q;
        count_d = count_q;

        if (state_q == StIdle) begin
            if (start) begin
                state_d = StLenLo;
                done_d  = 1'b0;
                err_d   = 1'b0;
                count_d = 16'd0;
                idx_d   = 2'd0;
                timer_d = '0;
            end
        end else begin
            // A byte arriving on the expiry cycle wins over the timeout.
            if (byte_valid) begin
                timer_d = '0;
            end else if (timer_exp) begin
                state_d = StIdle;
                err_d   = 1'b1;
            end else begin
                timer_d = timer_q + TW'(1);
            end

            if (byte_valid) begin
                case (state_q)
                    StLenLo: begin
                        len_d[7:0] = byte_data;
                        state_d    = StLenHi;
                    end
                    StLenHi: begin
                        len_d[15:8] = byte_data;
                        if (len_full == 16'd0 || {16'd0, len_full} > DEPTH) begin
                            err_d   = 1'b1;
                            state_d = StIdle;
                        end else begin
                            state_d = StData;
                        end
                    end
                    StData: begin
                        if (idx_q == 2'd3) begin
                            we_d    = 1'b1;
                            addr_d  = count_q[ADDR_W-1:0];
                            wdata_d = {byte_data, word_q};
                            count_d = count_inc;
                            idx_d   = 2'd0;
                            if (count_inc == len_q) begin
                                state_d = StIdle;
                                done_d  = 1'b1;
                            end
                        end else begin
                            word_d[{idx_q, 3'b000} +: 8] = byte_data;
                            idx_d = idx_q + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            len_q   <= 16'd0;
            idx_q   <= 2'd0;
            word_q  <= 24'd0;
            timer_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            timer_q <= timer_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign cpu_hold     = (state_q != StIdle);
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = count_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: directed framing cases plus random images checked against
// a byte-list model of the expected word writes.
module tb_inst_mem_loader;

    localparam int ADDR_W  = 14;
    localparam int DEPTH   = 16384;
    localparam int TIMEOUT = 100;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;
    logic [15:0]       words_loaded;

    inst_mem_loader #(
        .ADDR_W      (ADDR_W),
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Every write pulse seen, with the hold/done flags in that cycle.
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    logic        obs_done[$];
    logic        obs_hold[$];

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            obs_addr.push_back(32'(mem_addr));
            obs_data.push_back(mem_wdata);
            obs_done.push_back(done);
            obs_hold.push_back(cpu_hold);
        end
    end

    logic [7:0] img[$];

    task automatic clear_obs();
        obs_addr.delete();
        obs_data.delete();
        obs_done.delete();
        obs_hold.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic build_image(input int n);
        img.delete();
        img.push_back(n[7:0]);
        img.push_back(n[15:8]);
        for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
    endtask

    task automatic send_range(input int first, input int last, input int maxgap);
        for (int i = first; i <= last; i++) begin
            idle($urandom_range(0, maxgap));
            send_byte(img[i]);
        end
    endtask

    // Expected result of a complete image: word i at address i, little-endian bytes.
    task automatic check_load(input string tag);
        int n;
        int m;
        logic [31:0] w;
        n = int'(img[0]) + 256 * int'(img[1]);
        check({tag, "_nwrites"}, obs_addr.size(), n);
        m = (obs_addr.size() < n) ? obs_addr.size() : n;
        for (int i = 0; i < m; i++) begin
            w = 32'(img[2 + 4 * i]) | (32'(img[3 + 4 * i]) << 8) |
                (32'(img[4 + 4 * i]) << 16) | (32'(img[5 + 4 * i]) << 24);
            check($sformatf("%s_addr%0d", tag, i), obs_addr[i], i);
            check($sformatf("%s_data%0d", tag, i), obs_data[i], w);
            check($sformatf("%s_wdone%0d", tag, i), obs_done[i], (i == n - 1));
            check($sformatf("%s_whold%0d", tag, i), obs_hold[i], (i != n - 1));
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_err"}, err, 0);
        check({tag, "_wl"}, words_loaded, n);
        check({tag, "_hold"}, cpu_hold, 0);
    endtask

    task automatic run_load(input string tag, input int maxgap);
        clear_obs();
        pulse_start();
        send_range(0, img.size() - 1, maxgap);
        idle(3);
        check_load(tag);
    endtask

    task automatic check_aborted(input string tag);
        check({tag, "_err"}, err, 1);
        check({tag, "_done"}, done, 0);
        check({tag, "_hold"}, cpu_hold, 0);
        check({tag, "_nwrites"}, obs_addr.size(), 0);
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        idle(3);
        check("rst_we", mem_we, 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_hold", cpu_hold, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_wl", words_loaded, 0);
        rst = 1'b1;
        idle(2);

        // Basic two-word program
        img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        run_load("basic", 2);
        if (obs_data.size() == 2) begin
            check("basic_w0_const", obs_data[0], 32'h00100513);
            check("basic_w1_const", obs_data[1], 32'h00200593);
        end

        // Bytes in IDLE are ignored; state after the load is preserved
        clear_obs();
        for (int i = 0; i < 5; i++) send_byte(8'($urandom));
        idle(2);
        check("idle_bytes_wl", words_loaded, 2);
        check("idle_bytes_done", done, 1);
        check("idle_bytes_hold", cpu_hold, 0);
        check("idle_bytes_nwrites", obs_addr.size(), 0);

        // Back-to-back bytes, no gaps
        build_image(3);
        run_load("b2b", 0);

        // Zero length and one-over-depth length
        clear_obs();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        idle(2);
        check_aborted("len0");
        clear_obs();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h40);
        idle(2);
        check_aborted("len_over");

        // Length exactly DEPTH is accepted, then times out with no data
        clear_obs();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h40);
        idle(2);
        check("len_max_err", err, 0);
        check("len_max_hold", cpu_hold, 1);
        idle(TIMEOUT + 10);
        check_aborted("len_max_to");

        // Timeout mid-word
        clear_obs();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        idle(TIMEOUT / 2);
        check("to_early_err", err, 0);
        check("to_early_hold", cpu_hold, 1);
        idle(TIMEOUT / 2 + 10);
        check_aborted("to");
        build_image(2);
        run_load("after_to", 1);

        // Asynchronous reset mid-load, after 6 of 8 data bytes
        build_image(2);
        clear_obs();
        pulse_start();
        send_range(0, 7, 1);
        #2;
        rst = 1'b0;
        #1;
        check("mrst_we", mem_we, 0);
        check("mrst_addr", 32'(mem_addr), 0);
        check("mrst_wdata", mem_wdata, 0);
        check("mrst_hold", cpu_hold, 0);
        check("mrst_wl", words_loaded, 0);
        check("mrst_done", done, 0);
        check("mrst_err", err, 0);
        @(negedge clk);
        rst = 1'b1;
        clear_obs();
        send_range(8, 9, 0);
        for (int i = 0; i < 6; i++) send_byte(8'($urandom));
        idle(2);
        check("post_rst_hold", cpu_hold, 0);
        check("post_rst_wl", words_loaded, 0);
        check("post_rst_nwrites", obs_addr.size(), 0);

        // Start pulse during DATA is ignored
        build_image(2);
        clear_obs();
        pulse_start();
        send_range(0, 6, 1);
        pulse_start();
        send_range(7, img.size() - 1, 1);
        idle(3);
        check_load("start_in_data");

        // Random images with random gaps
        for (int k = 0; k < 6; k++) begin
            build_image($urandom_range(1, 6));
            run_load($sformatf("rnd%0d", k), 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
